localbus_arbiter: RTL

Two-master arbiter placed in front of `localbus`, sharing the single local bus port between master 0 (CPU data port) and master 1 (DMA / debug loader). It grants one master per cycle through a registered ownership state machine, supports locked bursts, and routes synchronous read data back to the issuing master with a tagged latency pipeline. Its bus-side outputs connect directly to the `localbus` `addr`/`qin`/`we`/`qout` ports.

---
 rtl/localbus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/localbus_arbiter.sv
// Two-master arbiter in front of localbus: registered ownership FSM, locked bursts, tagged read-return pipeline.
// Optional starvation guard: define LBARB_STARVE_GUARD_EN to break locks after MAX_WAIT cycles of waiting.
module localbus_arbiter #(
  parameter int XLEN     = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m1_req,
  input  logic            m0_lock,
  input  logic            m1_lock,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [3:0]      m0_we,
  input  logic [3:0]      m1_we,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_qin,
  output logic [3:0]      bus_we,
  input  logic [XLEN-1:0] bus_qout
);

  if (RD_LAT < 0 || RD_LAT > 2 || MAX_WAIT < 4 || MAX_WAIT > 255) begin : g_bad_param
    $error("localbus_arbiter: RD_LAT must be 0..2 and MAX_WAIT 4..255");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

  owner_e owner_q, owner_d;
  logic   rr_q, rr_d;
  logic   starve;
  logic   rd_push, rd_id;
  logic   tag_vld, tag_id;

  assign m0_gnt = (owner_q == OWN0) & m0_req;
  assign m1_gnt = (owner_q == OWN1) & m1_req;

  always_comb begin
    bus_addr = '0;
    bus_qin  = '0;
    bus_we   = '0;
    if (m0_gnt) begin
      bus_addr = m0_addr;
      bus_qin  = m0_wdata;
      bus_we   = m0_we;
    end else if (m1_gnt) begin
      bus_addr = m1_addr;
      bus_qin  = m1_wdata;
      bus_we   = m1_we;
    end
  end

  // An owner keeps the bus while it requests unless the other master waits and it is unlocked (or starving).
  always_comb begin
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (owner_q)
      IDLE: begin
        if (m0_req && m1_req) owner_d = rr_q ? OWN1 : OWN0;
        else if (m0_req)      owner_d = OWN0;
        else if (m1_req)      owner_d = OWN1;
      end
      OWN0: begin
        if (!m0_req)                           owner_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && (!m0_lock || starve)) owner_d = OWN1;
      end
      OWN1: begin
        if (!m1_req)                           owner_d = m0_req ? OWN0 : IDLE;
        else if (m0_req && (!m1_lock || starve)) owner_d = OWN0;
      end
      default: owner_d = IDLE;
    endcase
    if (m0_gnt)      rr_d = 1'b1;
    else if (m1_gnt) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef LBARB_STARVE_GUARD_EN
  logic [7:0] wait_q, wait_d;
  logic       waiting;

  assign waiting = ((owner_q == OWN0) & m1_req) | ((owner_q == OWN1) & m0_req);
  assign starve  = waiting && (wait_q >= 8'(MAX_WAIT - 1));

  // Counter restarts whenever ownership changes hands, so it always measures the current waiter.
  always_comb begin
    wait_d = 8'd0;
    if (waiting && (owner_d == owner_q))
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  assign rd_push = (m0_gnt & (m0_we == 4'd0)) | (m1_gnt & (m1_we == 4'd0));
  assign rd_id   = m1_gnt;

  if (RD_LAT == 0) begin : g_tag_comb
    assign tag_vld = rd_push;
    assign tag_id  = rd_id;
  end else begin : g_tag_pipe
    logic [RD_LAT-1:0] vld_q, id_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        id_q  <= '0;
      end else begin
        vld_q[0] <= rd_push;
        id_q[0]  <= rd_id;
        for (int i = 1; i < RD_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          id_q[i]  <= id_q[i-1];
        end
      end
    end

    assign tag_vld = vld_q[RD_LAT-1];
    assign tag_id  = id_q[RD_LAT-1];
  end

  assign m0_rvalid = tag_vld & ~tag_id;
  assign m1_rvalid = tag_vld & tag_id;
  assign m0_rdata  = m0_rvalid ? bus_qout : '0;
  assign m1_rdata  = m1_rvalid ? bus_qout : '0;

endmodule
